cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control sequencer for the 8-bit CPU datapath. It steps each instruction through FETCH, DECODE, EXECUTE, WRITEBACK and OUTPUT, and handles the instruction-fetch handshake. It issues the load, PC-increment and branch strobes, resolves conditional branches from the ALU result, traps invalid opcodes and halts, and supports run/single-step debug control. It replaces the inline state register in the CPU top level and drives the instruction register, program counter and output enable.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  1 = begin new instructions; 0 = stop at next FETCH boundary.
- step_mode  in  1  1 = one instruction per rising edge of `step`.
- step  in  1  single-step request, level, rising-edge detected internally.
- fetch_ready  in  1  instruction byte valid on the CPU input bus this cycle.
- decode_invalid  in  1  decoded control word is invalid (opcode nonzero, control word zero).
- halt_ins  in  1  decoded opcode is HALT.
- pc_load  in  1  control-word branch bit.
- out_ctl  in  1  control-word output bit.
- resume  in  1  leave HALT.
- alu_result  in  8  ALU result; branch is taken iff it equals 8'h01.
- state  out  3  FETCH=000, DECODE=001, EXECUTE=010, WRITEBACK=011, OUTPUT=100, HALT=101.
- fetch_req  out  1  requesting an instruction byte.
- ins_load  out  1  instruction register load strobe.
- pc_inc  out  1  PC increment strobe.
- pc_branch  out  1  PC load-from-immediate strobe.
- send_ins  out  1  instruction-done marker to the external program source.
- invalid_ins  out  1  invalid-opcode trap flag.
- out_en  out  1  drive the accumulator onto the output pins.
- halted  out  1  sequencer is in HALT.
- retired  out  8  count of completed instructions, wraps.
- err_cnt  out  4  count of invalid opcodes, saturates at 15.

## Operation
- Reset values:
  - state=FETCH.
  - All strobes, out_en and halted = 0.
  - retired=0, err_cnt=0.
  - Internal branch_pend, branch_taken and step_prev = 0.
- FETCH:
  - Fetch is granted when run=1 and (step_mode=0 or a step rising edge has been detected). In step mode the grant is latched until it is consumed.
  - While granted, fetch_req=1.
  - When fetch_ready=1 in the same cycle: ins_load=1, clear branch_pend and branch_taken, go to DECODE.
  - Otherwise stay in FETCH, with fetch_req=0 while not granted.
- DECODE:
  - If decode_invalid=1: invalid_ins=1, send_ins=1, pc_inc=1, err_cnt+1 (saturating), go to FETCH.
  - Else if halt_ins=1: go to HALT.
  - Else go to EXECUTE.
  - When both inputs are set, decode_invalid wins.
- EXECUTE: branch_pend ← pc_load, go to WRITEBACK.
- WRITEBACK: branch_taken ← branch_pend && (alu_result==8'h01), go to OUTPUT.
- OUTPUT:
  - send_ins=1, out_en=out_ctl, retired+1 (wraps 255→0), go to FETCH.
  - If branch_taken: pc_branch=1, else pc_inc=1. The two strobes are never high together.
- HALT:
  - halted=1 and all strobes 0.
  - resume=1 moves to FETCH with pc_inc=1 on that cycle, stepping past the HALT opcode.
  - The HALT opcode is not counted in retired.
- run=0 never aborts an instruction in flight. It only blocks the FETCH grant.
- A step edge seen outside FETCH is latched and consumed at the next FETCH. Further edges before consumption are dropped.
- step edges with step_mode=0 are ignored and not latched.
- Encodings 110 and 111 are illegal. If the state register ever holds one, go to FETCH on the next edge with no strobes.

## Timing
- All outputs are decoded combinationally from the registered state plus the current inputs. Counters are registered.
- Best-case instruction latency is 5 cycles, FETCH to OUTPUT inclusive, with fetch_ready high on the first FETCH cycle.
- Invalid opcode: 2 cycles from FETCH back to FETCH.
- Each strobe is high for exactly 1 cycle per event.
- retired and err_cnt update on the clock edge that ends OUTPUT or DECODE respectively.
- rst=1 on any edge, including mid-instruction or in HALT, forces the reset values on that edge. rst dominates resume, step and fetch_ready.

## Test plan
- Reset, then run=1, step_mode=0, fetch_ready=1, a valid non-branch opcode with out_ctl=1:
  - state sequence 000,001,010,011,100,000.
  - pc_inc and out_en high only in cycle 5; retired=1.
- Branch: pc_load=1 with alu_result=8'h01 in WRITEBACK gives pc_branch=1 and pc_inc=0 in OUTPUT. Repeat with alu_result=8'h02: pc_inc=1 and pc_branch=0.
- Invalid opcode (decode_invalid=1):
  - invalid_ins, send_ins and pc_inc all high in DECODE, then back to FETCH.
  - Repeat 17 times: err_cnt saturates at 15, retired unchanged.
- halt_ins=1:
  - Sequencer enters HALT and stays 10 cycles with all strobes 0.
  - resume pulse gives pc_inc=1 and state=FETCH.
  - halt_ins and decode_invalid together take the invalid path.
- Single-step: step_mode=1, fetch_ready=1, no step pulse for 20 cycles gives fetch_req=0. One step pulse runs exactly one instruction, then the sequencer waits again. Two pulses within one instruction yield only one extra instruction.
- Assert rst during EXECUTE and during HALT: next edge state=000, all outputs 0, and retired and err_cnt cleared. Run 256 instructions: retired wraps to 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer with fetch handshake, branch resolve, trap, halt and single-step
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step_mode,
    input  logic       step,
    input  logic       fetch_ready,
    input  logic       decode_invalid,
    input  logic       halt_ins,
    input  logic       pc_load,
    input  logic       out_ctl,
    input  logic       resume,
    input  logic [7:0] alu_result,
    output logic [2:0] state,
    output logic       fetch_req,
    output logic       ins_load,
    output logic       pc_inc,
    output logic       pc_branch,
    output logic       send_ins,
    output logic       invalid_ins,
    output logic       out_en,
    output logic       halted,
    output logic [7:0] retired,
    output logic [3:0] err_cnt
);
    typedef enum logic [2:0] {
        FETCH     = 3'b000,
        DECODE    = 3'b001,
        EXECUTE   = 3'b010,
        WRITEBACK = 3'b011,
        OUTPUT    = 3'b100,
        HALT      = 3'b101
    } state_t;

    state_t st;
    logic   branch_pend, branch_taken, step_prev, step_pend;
    logic   step_edge, grant;

    assign state     = st;
    assign step_edge = step & ~step_prev;
    // a step edge this cycle grants immediately; an earlier one is held in step_pend
    assign grant     = run & (~step_mode | step_pend | step_edge);

    // strobes decoded from the registered state and live inputs; reset holds them low
    always_comb begin
        fetch_req   = 1'b0;
        ins_load    = 1'b0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        send_ins    = 1'b0;
        invalid_ins = 1'b0;
        out_en      = 1'b0;
        halted      = 1'b0;
        if (!rst) begin
            case (st)
                FETCH: begin
                    fetch_req = grant;
                    ins_load  = grant & fetch_ready;
                end
                DECODE: begin
                    invalid_ins = decode_invalid;
                    send_ins    = decode_invalid;
                    pc_inc      = decode_invalid;
                end
                OUTPUT: begin
                    send_ins  = 1'b1;
                    out_en    = out_ctl;
                    pc_branch = branch_taken;
                    pc_inc    = ~branch_taken;
                end
                HALT: begin
                    halted = 1'b1;
                    pc_inc = resume;
                end
                default: ;
            endcase
        end
    end

    // state register, branch resolution, step latch and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= FETCH;
            branch_pend  <= 1'b0;
            branch_taken <= 1'b0;
            step_prev    <= 1'b0;
            step_pend    <= 1'b0;
            retired      <= 8'd0;
            err_cnt      <= 4'd0;
        end else begin
            step_prev <= step;
            step_pend <= (step_pend | (step_mode & step_edge)) & ~ins_load;
            case (st)
                FETCH: begin
                    if (ins_load) begin
                        branch_pend  <= 1'b0;
                        branch_taken <= 1'b0;
                        st           <= DECODE;
                    end
                end
                DECODE: begin
                    if (decode_invalid) begin
                        err_cnt <= (err_cnt == 4'hf) ? err_cnt : err_cnt + 4'd1;
                        st      <= FETCH;
                    end else begin
                        st <= halt_ins ? HALT : EXECUTE;
                    end
                end
                EXECUTE: begin
                    branch_pend <= pc_load;
                    st          <= WRITEBACK;
                end
                WRITEBACK: begin
                    branch_taken <= branch_pend && (alu_result == 8'h01);
                    st           <= OUTPUT;
                end
                OUTPUT: begin
                    retired <= retired + 8'd1;
                    st      <= FETCH;
                end
                HALT: begin
                    if (resume) st <= FETCH;
                end
                default: st <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of sequencing, branch, trap, halt, stepping, reset and counter wrap
module tb_cpu_sequencer;
    logic       clk = 1'b0;
    logic       rst, run, step_mode, step, fetch_ready, decode_invalid, halt_ins, pc_load, out_ctl, resume;
    logic [7:0] alu_result;
    logic [2:0] state;
    logic       fetch_req, ins_load, pc_inc, pc_branch, send_ins, invalid_ins, out_en, halted;
    logic [7:0] retired;
    logic [3:0] err_cnt;
    logic [7:0] strb;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_ret;
    logic [3:0] exp_err;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
        .fetch_ready(fetch_ready), .decode_invalid(decode_invalid), .halt_ins(halt_ins),
        .pc_load(pc_load), .out_ctl(out_ctl), .resume(resume), .alu_result(alu_result),
        .state(state), .fetch_req(fetch_req), .ins_load(ins_load), .pc_inc(pc_inc),
        .pc_branch(pc_branch), .send_ins(send_ins), .invalid_ins(invalid_ins),
        .out_en(out_en), .halted(halted), .retired(retired), .err_cnt(err_cnt)
    );

    assign strb = {fetch_req, ins_load, pc_inc, pc_branch, send_ins, invalid_ins, out_en, halted};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b1; fetch_ready = 1'b1;
        tick();
        #1;
        checks++;
        if ({state, retired, err_cnt, strb} !== 23'd0) begin
            errors++;
            $display("FAIL reset: state=%0d ret=%0d err=%0d strb=%b, want all 0", state, retired, err_cnt, strb);
        end
        rst = 1'b0; run = 1'b0; fetch_ready = 1'b0;
        exp_ret = 8'd0; exp_err = 4'd0;
    endtask

    task automatic test_basic;
        run = 1'b1; fetch_ready = 1'b1; out_ctl = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [2:0] es;
            es = i[2:0];
            if (i == 1) run = 1'b0;
            #1;
            checks++;
            if ({state, ins_load, pc_inc, out_en, send_ins} !== {es, i == 0, i == 4, i == 4, i == 4}) begin
                errors++;
                $display("FAIL basic cyc%0d: state=%0d ld=%b inc=%b oe=%b snd=%b, want state=%0d", i, state, ins_load, pc_inc, out_en, send_ins, es);
            end
            tick();
        end
        exp_ret++;
        out_ctl = 1'b0;
        #1;
        checks++;
        if ({state, retired, fetch_req} !== {3'd0, exp_ret, 1'b0}) begin
            errors++;
            $display("FAIL basic end: state=%0d ret=%0d req=%b, want 0 %0d 0", state, retired, fetch_req, exp_ret);
        end
    endtask

    task automatic test_branch;
        for (int k = 0; k < 2; k++) begin
            alu_result = (k == 0) ? 8'h01 : 8'h02;
            run = 1'b1; fetch_ready = 1'b1; pc_load = 1'b1;
            tick();
            run = 1'b0;
            tick(); tick(); tick();
            #1;
            checks++;
            if ({state, pc_branch, pc_inc} !== {3'd4, k == 0, k != 0}) begin
                errors++;
                $display("FAIL branch alu=%0h: state=%0d br=%b inc=%b, want 4 %b %b", alu_result, state, pc_branch, pc_inc, k == 0, k != 0);
            end
            tick();
            exp_ret++;
            pc_load = 1'b0;
        end
        #1;
        checks++;
        if ({state, retired} !== {3'd0, exp_ret}) begin
            errors++;
            $display("FAIL branch end: state=%0d ret=%0d, want 0 %0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_invalid;
        for (int i = 0; i < 17; i++) begin
            run = 1'b1; fetch_ready = 1'b1; decode_invalid = 1'b1;
            tick();
            run = 1'b0;
            #1;
            checks++;
            if ({state, invalid_ins, send_ins, pc_inc} !== {3'd1, 3'b111}) begin
                errors++;
                $display("FAIL invalid decode %0d: state=%0d inv=%b snd=%b inc=%b, want 1 1 1 1", i, state, invalid_ins, send_ins, pc_inc);
            end
            tick();
            if (exp_err != 4'hf) exp_err++;
            #1;
            checks++;
            if ({state, err_cnt, retired} !== {3'd0, exp_err, exp_ret}) begin
                errors++;
                $display("FAIL invalid after %0d: state=%0d err=%0d ret=%0d, want 0 %0d %0d", i, state, err_cnt, retired, exp_err, exp_ret);
            end
        end
        decode_invalid = 1'b0;
    endtask

    task automatic test_halt;
        run = 1'b1; fetch_ready = 1'b1; halt_ins = 1'b1;
        tick();
        run = 1'b0;
        tick();
        halt_ins = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({state, strb} !== {3'd5, 8'h01}) begin
                errors++;
                $display("FAIL halt hold %0d: state=%0d strb=%b, want 5 00000001", i, state, strb);
            end
            tick();
        end
        resume = 1'b1;
        #1;
        checks++;
        if ({state, pc_inc, halted} !== {3'd5, 2'b11}) begin
            errors++;
            $display("FAIL halt resume: state=%0d inc=%b halted=%b, want 5 1 1", state, pc_inc, halted);
        end
        tick();
        resume = 1'b0;
        #1;
        checks++;
        if ({state, retired} !== {3'd0, exp_ret}) begin
            errors++;
            $display("FAIL halt exit: state=%0d ret=%0d, want 0 %0d", state, retired, exp_ret);
        end
        run = 1'b1; halt_ins = 1'b1; decode_invalid = 1'b1;
        tick();
        run = 1'b0;
        #1;
        checks++;
        if ({state, invalid_ins} !== {3'd1, 1'b1}) begin
            errors++;
            $display("FAIL halt+invalid decode: state=%0d inv=%b, want 1 1", state, invalid_ins);
        end
        tick();
        halt_ins = 1'b0; decode_invalid = 1'b0; fetch_ready = 1'b0;
        #1;
        checks++;
        if ({state, err_cnt} !== {3'd0, exp_err}) begin
            errors++;
            $display("FAIL halt+invalid after: state=%0d err=%0d, want 0 %0d", state, err_cnt, exp_err);
        end
    endtask

    task automatic test_step;
        step_mode = 1'b0; run = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        step_mode = 1'b1; run = 1'b1; fetch_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if ({state, fetch_req} !== 4'd0) begin
                errors++;
                $display("FAIL step idle %0d: state=%0d req=%b, want 0 0", i, state, fetch_req);
            end
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            logic [2:0] es;
            es = (c < 10) ? 3'(c % 5) : 3'd0;
            step = (c == 0) || (c == 2) || (c == 4);
            #1;
            checks++;
            if ({state, fetch_req} !== {es, (c == 0) || (c == 5)}) begin
                errors++;
                $display("FAIL step seq cyc%0d: state=%0d req=%b, want %0d %b", c, state, fetch_req, es, (c == 0) || (c == 5));
            end
            tick();
        end
        exp_ret += 8'd2;
        step = 1'b0; step_mode = 1'b0; run = 1'b0; fetch_ready = 1'b0;
        #1;
        checks++;
        if (retired !== exp_ret) begin
            errors++;
            $display("FAIL step retired: got %0d want %0d", retired, exp_ret);
        end
    endtask

    task automatic test_reset_mid;
        run = 1'b1; fetch_ready = 1'b1;
        tick();
        run = 1'b0;
        tick();
        #1;
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL rst_exec pre: state=%0d want 2", state);
        end
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if ({state, retired, err_cnt, strb} !== 23'd0) begin
            errors++;
            $display("FAIL rst_exec: state=%0d ret=%0d err=%0d strb=%b, want all 0", state, retired, err_cnt, strb);
        end
        rst = 1'b0;
        run = 1'b1; decode_invalid = 1'b1;
        tick();
        tick();
        decode_invalid = 1'b0; halt_ins = 1'b1;
        tick();
        run = 1'b0;
        tick();
        halt_ins = 1'b0;
        #1;
        checks++;
        if ({state, err_cnt} !== {3'd5, 4'd1}) begin
            errors++;
            $display("FAIL rst_halt pre: state=%0d err=%0d, want 5 1", state, err_cnt);
        end
        rst = 1'b1; resume = 1'b1;
        tick();
        #1;
        checks++;
        if ({state, retired, err_cnt, strb} !== 23'd0) begin
            errors++;
            $display("FAIL rst_halt: state=%0d ret=%0d err=%0d strb=%b, want all 0", state, retired, err_cnt, strb);
        end
        rst = 1'b0; resume = 1'b0; fetch_ready = 1'b0;
        exp_ret = 8'd0; exp_err = 4'd0;
    endtask

    task automatic test_wrap;
        run = 1'b1; fetch_ready = 1'b1;
        repeat (1275) tick();
        #1;
        checks++;
        if ({state, retired} !== {3'd0, 8'd255}) begin
            errors++;
            $display("FAIL wrap 255: state=%0d ret=%0d, want 0 255", state, retired);
        end
        repeat (4) tick();
        run = 1'b0;
        tick();
        #1;
        checks++;
        if ({state, retired, err_cnt} !== {3'd0, 8'd0, 4'd0}) begin
            errors++;
            $display("FAIL wrap 256: state=%0d ret=%0d err=%0d, want 0 0 0", state, retired, err_cnt);
        end
        fetch_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0; fetch_ready = 1'b0;
        decode_invalid = 1'b0; halt_ins = 1'b0; pc_load = 1'b0; out_ctl = 1'b0;
        resume = 1'b0; alu_result = 8'h00;
        test_reset();
        test_basic();
        test_branch();
        test_invalid();
        test_halt();
        test_step();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
